button_debouncer: RTL

- Per-channel debouncer for synchronized button/switch inputs in the io_circuits path.
- Sits directly downstream of the sample-rate wrapping counter and consumes its one-cycle wrap pulse as `sample_pulse`.
- On each sample pulse, each channel's high input increments a saturating counter; a low input clears it.
- A channel is declared pressed once SAT_CNT_MAX consecutive high samples have been seen. A one-cycle rising-edge strobe is also produced for downstream consumers such as the CPU MMIO button register.

---
 rtl/button_debouncer.sv | 50 +++++
 1 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel saturating-count button debouncer with rising-edge strobe
module button_debouncer #(
    parameter int WIDTH       = 1,
    parameter int SAT_CNT_MAX = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_pulse,
    input  logic [WIDTH-1:0] glitchy_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] edge_out
);

    localparam int SAT_WIDTH = $clog2(SAT_CNT_MAX + 1);
    localparam logic [SAT_WIDTH-1:0] SAT_TOP = SAT_WIDTH'(SAT_CNT_MAX);

    logic [SAT_WIDTH-1:0] sat_cnt [WIDTH];
    logic [WIDTH-1:0]     deb_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                sat_cnt[i] <= '0;
            end
            deb_prev <= '0;
        end else begin
            deb_prev <= debounced_out;
            if (sample_pulse) begin
                for (int i = 0; i < WIDTH; i++) begin
                    // Any low sample restarts the run; a full run saturates rather than wrapping.
                    if (!glitchy_in[i]) begin
                        sat_cnt[i] <= '0;
                    end else if (sat_cnt[i] != SAT_TOP) begin
                        sat_cnt[i] <= sat_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        debounced_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            debounced_out[i] = (sat_cnt[i] == SAT_TOP);
        end
    end

    assign edge_out = debounced_out & ~deb_prev;

endmodule
